vga_scan_reader: RTL

Read side of the 160x120 pixel framebuffer. The game renderer writes this framebuffer through the plot/x/y/colour port. This block generates 640x480@60 Hz VGA timing from the 50 MHz system clock and fetches each 160x120 framebuffer pixel through a synchronous read port. Each framebuffer pixel is replicated 4x4 on screen. The block drives 3-bit colour plus sync/blank to the DAC, and emits a one-cycle vertical-blank pulse that the game logic uses as its frame tick.

---
 rtl/vga_scan_reader.sv | 89 ++++++++
 1 files changed

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480@60 VGA timing that scans a 160x120 framebuffer, each pixel shown as a 4x4 block,
// and outputs the colour one pixel tick after the framebuffer read.
module vga_scan_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [2:0]  rd_data,
    output logic [2:0]  colour_out,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vblank_pulse
);
    localparam logic [9:0]  H_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS   = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_VLAST = 10'(V_ACTIVE - 1);
    localparam logic [14:0] ROW_INC = 15'(FB_W);

    logic        phase;
    logic [9:0]  h_cnt, v_cnt;
    logic [14:0] row_base;
    logic        hs_a, vs_a, blank_a;
    logic        visible, hs_raw, vs_raw, h_wrap, v_wrap;

    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        h_wrap  = h_cnt == H_LAST;
        v_wrap  = v_cnt == V_LAST;
    end

    // Everything except phase and vblank_pulse advances only on the 25 MHz pixel tick (phase==1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase        <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            row_base     <= '0;
            rd_addr      <= '0;
            rd_en        <= 1'b0;
            hs_a         <= 1'b1;
            vs_a         <= 1'b1;
            blank_a      <= 1'b0;
            colour_out   <= '0;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_blank_n  <= 1'b0;
            vblank_pulse <= 1'b0;
        end else begin
            phase        <= ~phase;
            vblank_pulse <= phase && h_wrap && (v_cnt == V_VLAST);
            if (phase) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
                if (h_wrap) begin
                    v_cnt    <= v_wrap ? '0 : v_cnt + 10'd1;
                    row_base <= v_wrap ? '0 : (v_cnt[1:0] == 2'd3 ? row_base + ROW_INC : row_base);
                end
                rd_en <= visible;
                if (visible)
                    rd_addr <= row_base + {7'd0, h_cnt[9:2]};
                hs_a        <= hs_raw;
                vs_a        <= vs_raw;
                blank_a     <= visible;
                colour_out  <= blank_a ? rd_data : 3'b000;
                vga_hs      <= hs_a;
                vga_vs      <= vs_a;
                vga_blank_n <= blank_a;
            end
        end
    end
endmodule
